spi_hdr_router: RTL and testbench

- Parametrised successor to the fixed 7-way SPI fan-out switch.
- The MCU SPI bus is oversampled in the sys_clk domain. The first byte of each CS frame is a routing header that selects one of N_CH downstream slaves, or all of them as a broadcast.
- The rest of the frame is forwarded to the selected slave(s), and that slave's MISO is returned to the MCU.
- Sits between the MCU SPI pins and the slave SPI ports at the FPGA top level. Adds frame/error status outputs for the housekeeping logic.

---
 rtl/spi_hdr_router.sv | 171 +++++++++++++++++
 tb/tb_spi_hdr_router.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_hdr_router.sv
// spi_hdr_router
//   Oversamples an MCU SPI bus (mode 0) in the sys_clk domain. The first byte
//   of each chip-select frame is a routing header:
//     hdr[7] = 1            -> broadcast the rest of the frame to all slaves
//     hdr[7] = 0, ch < N_CH -> forward the rest of the frame to slave ch
//     otherwise             -> flag hdr_err and discard the frame
//   The selected slave's MISO is returned to the MCU. In broadcast it reads 0.
//
// Ports
//   sys_clk, sys_rst     system clock, asynchronous active-high reset
//   mcu_spi_clk/cs/mosi  MCU SPI inputs (cs active-low), asynchronous to sys_clk
//   mcu_spi_miso         data returned to the MCU
//   slave_spi_clk/mosi   per-slave SCLK/MOSI, registered copies of the MCU bus
//   slave_spi_cs         per-slave chip select, active-low
//   slave_spi_miso       per-slave MISO
//   active_ch            channel of the current or last unicast frame
//   busy                 FSM not idle
//   bcast                broadcast frame being forwarded
//   hdr_err              one-cycle pulse on an out-of-range header
//   frame_done           one-cycle pulse at the end of a forwarded frame
module spi_hdr_router #(
  parameter int N_CH        = 7,
  parameter int CH_W        = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            mcu_spi_clk,
  input  logic            mcu_spi_cs,
  input  logic            mcu_spi_mosi,
  output logic            mcu_spi_miso,
  output logic [N_CH-1:0] slave_spi_clk,
  output logic [N_CH-1:0] slave_spi_mosi,
  output logic [N_CH-1:0] slave_spi_cs,
  input  logic [N_CH-1:0] slave_spi_miso,
  output logic [CH_W-1:0] active_ch,
  output logic            busy,
  output logic            bcast,
  output logic            hdr_err,
  output logic            frame_done
);

  typedef enum logic [1:0] {IDLE, HEADER, FORWARD, DISCARD} state_t;

  localparam logic [6:0] N_CH_HDR = 7'(N_CH);

  logic [SYNC_STAGES-1:0] sclk_p0, cs_p0, mosi_p0;
  logic                   sclk_p1, cs_p1;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t          state, state_nxt;
  logic [7:0]      hdr;
  logic [3:0]      bit_cnt;
  logic            hdr_in_range, hdr_ok, hdr_dec;
  logic [N_CH-1:0] sel, sel_dec, sel_nxt, fwd_mask;
  logic            miso_sel;

  // ---- stage p0: synchronisers; stage p1: edge-reference copies ----
  // The CS chain resets low so that a CS already held low when reset is
  // released is not mistaken for a new falling edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sclk_p0 <= '0;
      cs_p0   <= '0;
      sclk_p1 <= 1'b0;
      cs_p1   <= 1'b0;
    end else begin
      sclk_p0 <= {sclk_p0[SYNC_STAGES-2:0], mcu_spi_clk};
      cs_p0   <= {cs_p0[SYNC_STAGES-2:0], mcu_spi_cs};
      sclk_p1 <= sclk_s;
      cs_p1   <= cs_s;
    end
  end

  always_ff @(posedge sys_clk) begin
    mosi_p0 <= {mosi_p0[SYNC_STAGES-2:0], mcu_spi_mosi};
  end

  assign sclk_s    = sclk_p0[SYNC_STAGES-1];
  assign cs_s      = cs_p0[SYNC_STAGES-1];
  assign mosi_s    = mosi_p0[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_p1;
  assign sclk_fall = ~sclk_s & sclk_p1;
  assign cs_rise   = cs_s & ~cs_p1;
  assign cs_fall   = ~cs_s & cs_p1;

  // ---- header decode and routing FSM ----
  // A CS rising edge takes priority over any SCLK edge in the same cycle.
  always_comb begin
    hdr_in_range = (hdr[6:0] < N_CH_HDR);
    hdr_ok       = hdr[7] | hdr_in_range;
    hdr_dec      = (state == HEADER) && !cs_rise && (bit_cnt == 4'd8) && sclk_fall;
    sel_dec      = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_dec[i] = hdr[7] | (hdr[6:0] == 7'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = HEADER;
      HEADER: begin
        if (cs_rise)      state_nxt = IDLE;
        else if (hdr_dec) state_nxt = hdr_ok ? FORWARD : DISCARD;
      end
      FORWARD: if (cs_rise) state_nxt = IDLE;
      DISCARD: if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  assign sel_nxt  = hdr_dec ? sel_dec : sel;
  assign fwd_mask = (state_nxt == FORWARD) ? sel_nxt : '0;
  assign busy     = (state != IDLE);

  // ---- stage p2: registered slave-side outputs and status ----
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hdr            <= '0;
      bit_cnt        <= '0;
      sel            <= '0;
      active_ch      <= '0;
      bcast          <= 1'b0;
      hdr_err        <= 1'b0;
      frame_done     <= 1'b0;
      slave_spi_cs   <= '1;
      slave_spi_clk  <= '0;
      slave_spi_mosi <= '0;
    end else begin
      hdr_err    <= hdr_dec && !hdr_ok;
      frame_done <= (state == FORWARD) && cs_rise;

      if ((state == IDLE) && cs_fall) begin
        hdr     <= '0;
        bit_cnt <= '0;
      end else if ((state == HEADER) && sclk_rise && (bit_cnt != 4'd8)) begin
        hdr     <= {hdr[6:0], mosi_s};
        bit_cnt <= bit_cnt + 4'd1;
      end

      if (hdr_dec && hdr_ok) begin
        sel   <= sel_dec;
        bcast <= hdr[7];
        if (!hdr[7]) active_ch <= hdr[CH_W-1:0];
      end else if ((state == FORWARD) && cs_rise) begin
        bcast <= 1'b0;
      end

      slave_spi_cs   <= ~fwd_mask;
      slave_spi_clk  <= fwd_mask & {N_CH{sclk_s}};
      slave_spi_mosi <= fwd_mask & {N_CH{mosi_s}};
    end
  end

  // ---- MISO return path (combinational) ----
  always_comb begin
    miso_sel = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (active_ch == CH_W'(i)) miso_sel = slave_spi_miso[i];
    end
    mcu_spi_miso = ((state == FORWARD) && !bcast) ? miso_sel : 1'b0;
  end

endmodule

// File: tb/tb_spi_hdr_router.sv
// tb_spi_hdr_router
//   Self-checking bench for spi_hdr_router (N_CH=7). An MCU model drives SPI
//   frames; per-slave models capture forwarded data and shift out MISO
//   patterns. Expected results come from a directed table, hand-written
//   corner-case sequences and a frame-level reference model for random frames.
module tb_spi_hdr_router;

  localparam int N_CH = 7;
  localparam int CH_W = 3;
  localparam int SS   = 2;
  localparam int HALF = 6;

  logic            clk = 1'b0;
  logic            sys_rst;
  logic            mcu_sclk, mcu_cs, mcu_mosi;
  logic            mcu_spi_miso;
  logic [N_CH-1:0] slave_spi_clk, slave_spi_mosi, slave_spi_cs;
  logic [N_CH-1:0] slave_miso;
  logic [CH_W-1:0] active_ch;
  logic            busy, bcast, hdr_err, frame_done;

  spi_hdr_router #(.N_CH(N_CH), .CH_W(CH_W), .SYNC_STAGES(SS)) dut (
    .sys_clk(clk), .sys_rst(sys_rst),
    .mcu_spi_clk(mcu_sclk), .mcu_spi_cs(mcu_cs), .mcu_spi_mosi(mcu_mosi),
    .mcu_spi_miso(mcu_spi_miso),
    .slave_spi_clk(slave_spi_clk), .slave_spi_mosi(slave_spi_mosi),
    .slave_spi_cs(slave_spi_cs), .slave_spi_miso(slave_miso),
    .active_ch(active_ch), .busy(busy), .bcast(bcast),
    .hdr_err(hdr_err), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // slave-side observers
  logic            mon_clr = 1'b1;
  logic [15:0]     pat [N_CH];
  logic [15:0]     tx [N_CH];
  logic [31:0]     rx_sl [N_CH];
  int              cs_falls [N_CH];
  int              nrx [N_CH];
  int              viol [N_CH];
  int              done_cnt, err_cnt;
  logic [N_CH-1:0] prev_cs = '1;
  logic [N_CH-1:0] prev_clk = '0;

  always @(negedge clk) begin
    prev_cs  <= slave_spi_cs;
    prev_clk <= slave_spi_clk;
    if (mon_clr) begin
      done_cnt <= 0;
      err_cnt  <= 0;
      for (int i = 0; i < N_CH; i++) begin
        cs_falls[i] <= 0;
        nrx[i]      <= 0;
        rx_sl[i]    <= '0;
        viol[i]     <= 0;
        tx[i]       <= '0;
      end
    end else begin
      if (frame_done) done_cnt <= done_cnt + 1;
      if (hdr_err)    err_cnt  <= err_cnt + 1;
      for (int i = 0; i < N_CH; i++) begin
        if (prev_cs[i] && !slave_spi_cs[i]) begin
          cs_falls[i] <= cs_falls[i] + 1;
          tx[i]       <= pat[i];
        end else if (!slave_spi_cs[i] && prev_clk[i] && !slave_spi_clk[i]) begin
          tx[i] <= {tx[i][14:0], 1'b0};
        end
        if (!slave_spi_cs[i] && !prev_clk[i] && slave_spi_clk[i]) begin
          rx_sl[i] <= {rx_sl[i][30:0], slave_spi_mosi[i]};
          nrx[i]   <= nrx[i] + 1;
        end
        if (slave_spi_cs[i] && (slave_spi_clk[i] || slave_spi_mosi[i]))
          viol[i] <= viol[i] + 1;
      end
    end
  end

  always_comb begin
    slave_miso = '0;
    for (int i = 0; i < N_CH; i++) slave_miso[i] = tx[i][15];
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic half_wait();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(posedge clk);
    @(posedge clk);
    mon_clr = 1'b0;
    @(negedge clk);
  endtask

  // one SPI mode-0 bit: data set up, MISO/bcast sampled just before the rising edge
  task automatic xfer_bit(input logic b, output logic s, output logic bc);
    mcu_mosi = b;
    half_wait();
    s  = mcu_spi_miso;
    bc = bcast;
    mcu_sclk = 1'b1;
    half_wait();
    mcu_sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] h, input int nhdr, input int nbits,
                            input logic [31:0] d, input int post,
                            output logic [31:0] rx, output int mbad,
                            output logic bcm, output logic bl);
    logic s, b;
    rx = '0; mbad = 0; bcm = 1'b0;
    mcu_cs = 1'b0;
    for (int k = 0; k < nhdr; k++) begin
      xfer_bit(h[7-k], s, b);
      if (s !== 1'b0) mbad++;
    end
    for (int k = 0; k < nbits; k++) begin
      xfer_bit(d[nbits-1-k], s, b);
      rx = {rx[30:0], s};
      if (k == 0) bcm = b;
    end
    half_wait();
    bl = busy;
    mcu_cs   = 1'b1;
    mcu_mosi = 1'b0;
    repeat (post) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int nbits, input logic [31:0] d,
                             input logic [31:0] rx, input int mbad, input logic bcm,
                             input logic bl, input logic [N_CH-1:0] esel,
                             input logic eerr, input logic edone, input logic ebc,
                             input logic [31:0] erx, input logic [CH_W-1:0] ech);
    logic [31:0] mask;
    mask = (nbits == 0) ? 32'h0 : (32'hFFFF_FFFF >> (32 - nbits));
    $display("[TB] frame %s", tag);
    for (int i = 0; i < N_CH; i++) begin
      chk("slave_cs_falls", i, cs_falls[i], 32'(esel[i]));
      chk("slave_clk_count", i, nrx[i], esel[i] ? nbits : 0);
      chk("slave_idle_activity", i, viol[i], 0);
      if (esel[i] && nbits > 0) chk("slave_rx_data", i, rx_sl[i] & mask, d & mask);
    end
    chk("hdr_err_pulses", 0, err_cnt, 32'(eerr));
    chk("frame_done_pulses", 0, done_cnt, 32'(edone));
    chk("mcu_rx_data", 0, rx, erx);
    chk("mcu_miso_in_header", 0, mbad, 0);
    chk("busy_before_cs_rise", 0, 32'(bl), 1);
    if (nbits > 0) chk("bcast_during_data", 0, 32'(bcm), 32'(ebc));
    chk("busy_after", 0, 32'(busy), 0);
    chk("bcast_after", 0, 32'(bcast), 0);
    chk("active_ch", 0, 32'(active_ch), 32'(ech));
    chk("slave_cs_after", 0, 32'(slave_spi_cs), 32'(7'h7F));
    chk("slave_clk_mosi_after", 0, 32'({slave_spi_clk, slave_spi_mosi}), 0);
  endtask

  typedef struct {
    logic [7:0]      hdr;
    int              nbits;
    logic [31:0]     data;
    logic [N_CH-1:0] sel;
    logic            err;
    logic            done;
    logic            bc;
    logic [31:0]     rx;
    logic [CH_W-1:0] ch;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]     rx, rx1, rx2;
    int              mbad;
    logic            bcm, bl, s, b;
    logic [7:0]      h;
    logic [CH_W-1:0] model_ch;
    logic [N_CH-1:0] esel;
    logic            valid;
    logic [31:0]     erx;
    int              nb;
    logic [31:0]     d;
    logic [7:0]      hsave;
    logic [31:0]     dsave;

    //            hdr    nbits data        sel         err   done  bc    rx         ch
    tbl[0] = '{8'h03, 16, 32'hA55A, 7'b0001000, 1'b0, 1'b1, 1'b0, 32'h1234, 3'd3};
    tbl[1] = '{8'h80,  8, 32'h00C3, 7'b1111111, 1'b0, 1'b1, 1'b1, 32'h0,    3'd3};
    tbl[2] = '{8'h09, 16, 32'hBEEF, 7'b0000000, 1'b1, 1'b0, 1'b0, 32'h0,    3'd3};
    tbl[3] = '{8'h06,  0, 32'h0,    7'b1000000, 1'b0, 1'b1, 1'b0, 32'h0,    3'd6};
    tbl[4] = '{8'h7F,  8, 32'h0055, 7'b0000000, 1'b1, 1'b0, 1'b0, 32'h0,    3'd6};
    tbl[5] = '{8'h00, 12, 32'h0ABC, 7'b0000001, 1'b0, 1'b1, 1'b0, 32'h111,  3'd0};
    tbl[6] = '{8'hFF,  4, 32'h0009, 7'b1111111, 1'b0, 1'b1, 1'b1, 32'h0,    3'd0};
    tbl[7] = '{8'h07,  3, 32'h0005, 7'b0000000, 1'b1, 1'b0, 1'b0, 32'h0,    3'd0};

    for (int i = 0; i < N_CH; i++) pat[i] = 16'(16'h1111 * (i + 1));
    pat[3] = 16'h1234;

    sys_rst = 1'b1; mcu_sclk = 1'b0; mcu_cs = 1'b1; mcu_mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_slave_cs", 0, 32'(slave_spi_cs), 32'(7'h7F));
    chk("rst_slave_clk", 0, 32'(slave_spi_clk), 0);
    chk("rst_slave_mosi", 0, 32'(slave_spi_mosi), 0);
    chk("rst_status", 0, 32'({mcu_spi_miso, active_ch, busy, bcast, hdr_err, frame_done}), 0);
    sys_rst = 1'b0;
    repeat (5) @(negedge clk);
    clear_mon();

    // directed table
    for (int t = 0; t < 8; t++) begin
      clear_mon();
      send_frame(tbl[t].hdr, 8, tbl[t].nbits, tbl[t].data, 10, rx, mbad, bcm, bl);
      check_frame($sformatf("table%0d", t), tbl[t].nbits, tbl[t].data, rx, mbad, bcm, bl,
                  tbl[t].sel, tbl[t].err, tbl[t].done, tbl[t].bc, tbl[t].rx, tbl[t].ch);
    end
    model_ch = 3'd0;

    // CS rises after 5 header bits
    clear_mon();
    send_frame(8'hA5, 5, 0, 32'h0, 10, rx, mbad, bcm, bl);
    check_frame("abort_in_header", 0, 32'h0, rx, mbad, bcm, bl, '0, 1'b0, 1'b0, 1'b0,
                32'h0, model_ch);

    // reset asserted mid-data on channel 2
    clear_mon();
    hsave = 8'h02; dsave = 32'h0000_00B7; mbad = 0;
    mcu_cs = 1'b0;
    for (int k = 0; k < 8; k++) begin
      xfer_bit(hsave[7-k], s, b);
      if (s !== 1'b0) mbad++;
    end
    for (int k = 0; k < 4; k++) xfer_bit(dsave[7-k], s, b);
    chk("rst_mid_miso_hdr", 0, mbad, 0);
    chk("rst_mid_cs2_before", 0, 32'(slave_spi_cs), 32'(7'b1111011));
    #2 sys_rst = 1'b1;
    #1 chk("rst_mid_cs_async", 0, 32'(slave_spi_cs), 32'(7'h7F));
    chk("rst_mid_busy", 0, 32'(busy), 0);
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;
    clear_mon();
    for (int k = 4; k < 8; k++) xfer_bit(dsave[7-k], s, b);
    half_wait();
    mcu_cs = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < N_CH; i++) chk("rst_tail_cs_falls", i, cs_falls[i], 0);
    chk("rst_tail_done", 0, done_cnt, 0);
    chk("rst_tail_err", 0, err_cnt, 0);
    chk("rst_tail_active_ch", 0, 32'(active_ch), 0);
    clear_mon();
    send_frame(8'h01, 8, 8, 32'h5A, 10, rx, mbad, bcm, bl);
    model_ch = 3'd1;
    check_frame("after_reset", 8, 32'h5A, rx, mbad, bcm, bl, 7'b0000010, 1'b0, 1'b1, 1'b0,
                32'(pat[1] >> 8), model_ch);

    // back-to-back frames with the minimum CS-high gap
    clear_mon();
    send_frame(8'h00, 8, 8, 32'h3C, SS + 2, rx1, mbad, bcm, bl);
    chk("b2b_active_ch_first", 0, 32'(active_ch), 0);
    send_frame(8'h06, 8, 8, 32'h96, 10, rx2, mbad, bcm, bl);
    chk("b2b_done", 0, done_cnt, 2);
    chk("b2b_cs0_falls", 0, cs_falls[0], 1);
    chk("b2b_cs6_falls", 0, cs_falls[6], 1);
    chk("b2b_rx_slave0", 0, rx_sl[0], 32'h3C);
    chk("b2b_rx_slave6", 0, rx_sl[6], 32'h96);
    chk("b2b_mcu_rx0", 0, rx1, 32'(pat[0] >> 8));
    chk("b2b_mcu_rx6", 0, rx2, 32'(pat[6] >> 8));
    chk("b2b_active_ch_second", 0, 32'(active_ch), 6);
    model_ch = 3'd6;

    // random frames against the frame-level model
    for (int f = 0; f < 20; f++) begin
      case ($urandom_range(0, 3))
        0:       h = 8'($urandom_range(0, N_CH - 1));
        1:       h = 8'h80 | 8'($urandom_range(0, 127));
        2:       h = 8'($urandom_range(N_CH, 127));
        default: h = 8'($urandom);
      endcase
      nb = int'($urandom_range(0, 16));
      d  = $urandom;
      for (int i = 0; i < N_CH; i++) pat[i] = 16'($urandom);

      valid = h[7] || (int'(h[6:0]) < N_CH);
      if (!valid)    esel = '0;
      else if (h[7]) esel = '1;
      else           esel = N_CH'(1) << h[6:0];
      erx = 32'h0;
      if (valid && !h[7]) begin
        model_ch = h[CH_W-1:0];
        if (nb > 0) erx = 32'(pat[h[2:0]]) >> (16 - nb);
      end

      clear_mon();
      send_frame(h, 8, nb, d, 10, rx, mbad, bcm, bl);
      check_frame($sformatf("random%0d hdr=%02h nbits=%0d", f, h, nb), nb, d, rx, mbad,
                  bcm, bl, esel, !valid, valid, h[7] && valid, erx, model_ch);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
